nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_adder_pkg.sv | 12 +
 rtl/cla_nibble.sv | 31 +++
 rtl/nibble_serial_adder.sv | 114 +++++++++++
 tb/tb_nibble_serial_adder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_adder_pkg.sv
// Shared FSM state encoding and nibble width for the nibble-serial adder.
package nibble_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_nibble.sv
// 4-bit carry-lookahead adder slice, purely combinational (zero latency).
// No flow control; the caller sequences nibbles.
module cla_nibble
  import nibble_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of products of g/p and cin, so none waits on another.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIB_W-1:0];
  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder, one nibble per cycle: out_valid rises N_NIB cycles after acceptance.
// Result held in DONE until out_ready; in_ready only in IDLE. Macro NIBBLE_SERIAL_ADDER_SUB_EN adds subtract.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int N_NIB = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*N_NIB-1:0] a,
  input  logic [NIB_W*N_NIB-1:0] b,
  input  logic                   cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic                   sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*N_NIB-1:0] sum,
  output logic                   cout
);

  localparam int W  = NIB_W * N_NIB;
  localparam int IW = $clog2(N_NIB);

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic             carry_q;
  logic [IW-1:0]    idx;

  logic [W-1:0]     b_acc;
  logic             cin_acc;
  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_cout;

  // Subtraction is folded into the captured operand so the add datapath is shared.
  always_comb begin
    b_acc   = b;
    cin_acc = cin;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    if (sub) begin
      b_acc   = ~b;
      cin_acc = 1'b1;
    end
`endif
  end

  assign nib_a = a_q[idx*NIB_W +: NIB_W];
  assign nib_b = b_q[idx*NIB_W +: NIB_W];

  cla_nibble u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b_acc;
            carry_q  <= cin_acc;
            idx      <= '0;
            state    <= ADD;
            in_ready <= 1'b0;
          end
        end
        ADD: begin
          sum[idx*NIB_W +: NIB_W] <= nib_sum;
          carry_q                 <= nib_cout;
          if (idx == IW'(N_NIB - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            cout      <= nib_cout;
            idx       <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with N_NIB=4.
module tb_nibble_serial_adder;

  localparam int N_NIB = 4;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         cin_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         sub_i;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.N_NIB(N_NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub_i),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Present one operand set, optionally scramble inputs afterwards, and
  // report how many cycles after acceptance out_valid was seen (-1 = never).
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        input bit scramble, output int lat);
    @(negedge clk);
    a_i = av; b_i = bv; cin_i = cv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (scramble) begin
        a_i   = ~a_i ^ 16'(k);
        b_i   = b_i + 16'h3333;
        cin_i = ~cin_i;
      end
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (sum !== 16'h0000) begin bad++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout: got %b expected 0", cout); end
  endtask

  task automatic test_add_basic;
    int lat;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, lat);
    total += 4;
    if (lat !== 4) begin bad++; $display("FAIL basic_latency: got %0d expected 4", lat); end
    if (sum !== 16'h5555) begin bad++; $display("FAIL basic_sum: got %h expected 5555", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout: got %b expected 0", cout); end
    if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_done: got %b expected 0", in_ready); end
    release_out;
    total += 2;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_idle: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_idle: got %b expected 0", out_valid); end
  endtask

  task automatic test_carry;
    logic [W-1:0] va [5] = '{16'h0F0F, 16'hFFFF, 16'h000F, 16'hFFFF, 16'h8000};
    logic [W-1:0] vb [5] = '{16'h00F1, 16'h0001, 16'h0000, 16'hFFFF, 16'h8000};
    logic         vc [5] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    logic [W-1:0] es [5] = '{16'h1000, 16'h0000, 16'h0010, 16'hFFFF, 16'h0000};
    logic         ec [5] = '{1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
    int lat;
    for (int i = 0; i < 5; i++) begin
      run_op(va[i], vb[i], vc[i], 1'b0, lat);
      total += 3;
      if (lat !== 4) begin bad++; $display("FAIL carry_latency[%0d]: got %0d expected 4", i, lat); end
      if (sum !== es[i]) begin bad++; $display("FAIL carry_sum[%0d]: got %h expected %h", i, sum, es[i]); end
      if (cout !== ec[i]) begin bad++; $display("FAIL carry_cout[%0d]: got %b expected %b", i, cout, ec[i]); end
      release_out;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    run_op(16'hA5A5, 16'h1234, 1'b1, 1'b0, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL bp_latency: got %0d expected 4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total += 4;
      if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, out_valid); end
      if (sum !== 16'hB7DA) begin bad++; $display("FAIL bp_sum[%0d]: got %h expected b7da", i, sum); end
      if (cout !== 1'b0) begin bad++; $display("FAIL bp_cout[%0d]: got %b expected 0", i, cout); end
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    // New operands offered on the draining edge must not be taken.
    a_i = 16'h1111; b_i = 16'h2222; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL drain_in_ready: got %b expected 1", in_ready); end
    if (sum !== 16'hB7DA) begin bad++; $display("FAIL idle_sum_hold: got %h expected b7da", sum); end
  endtask

  task automatic test_reset_in_add;
    int seen;
    @(negedge clk);
    a_i = 16'h1111; b_i = 16'h1111; cin_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total += 4;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_in_ready: got %b expected 1", in_ready); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_out_valid: got %b expected 0", out_valid); end
    if (sum !== 16'h0000) begin bad++; $display("FAIL abort_sum: got %h expected 0000", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL abort_cout: got %b expected 0", cout); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_late_valid: got %0d cycles expected 0", seen); end
  endtask

  task automatic test_operand_change;
    int lat;
    run_op(16'h1234, 16'h4321, 1'b0, 1'b1, lat);
    total += 3;
    if (lat !== 4) begin bad++; $display("FAIL hold_latency0: got %0d expected 4", lat); end
    if (sum !== 16'h5555) begin bad++; $display("FAIL hold_sum0: got %h expected 5555", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL hold_cout0: got %b expected 0", cout); end
    release_out;
    run_op(16'h9999, 16'h8888, 1'b0, 1'b1, lat);
    total += 2;
    if (sum !== 16'h2221) begin bad++; $display("FAIL hold_sum1: got %h expected 2221", sum); end
    if (cout !== 1'b1) begin bad++; $display("FAIL hold_cout1: got %b expected 1", cout); end
    release_out;
  endtask

  task automatic test_back_to_back;
    int lat;
    run_op(16'h0FF0, 16'h0010, 1'b1, 1'b0, lat);
    total += 2;
    if (sum !== 16'h1001) begin bad++; $display("FAIL b2b_sum0: got %h expected 1001", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL b2b_cout0: got %b expected 0", cout); end
    release_out;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    total += 3;
    if (lat !== 4) begin bad++; $display("FAIL b2b_latency1: got %0d expected 4", lat); end
    if (sum !== 16'h8000) begin bad++; $display("FAIL b2b_sum1: got %h expected 8000", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL b2b_cout1: got %b expected 0", cout); end
    release_out;
  endtask

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat;
    sub_i = 1'b1;
    run_op(16'h0005, 16'h0007, 1'b0, 1'b0, lat);
    total += 2;
    if (sum !== 16'hFFFE) begin bad++; $display("FAIL sub_sum0: got %h expected fffe", sum); end
    if (cout !== 1'b0) begin bad++; $display("FAIL sub_cout0: got %b expected 0", cout); end
    release_out;
    run_op(16'h0007, 16'h0005, 1'b1, 1'b0, lat);
    total += 2;
    if (sum !== 16'h0002) begin bad++; $display("FAIL sub_sum1: got %h expected 0002", sum); end
    if (cout !== 1'b1) begin bad++; $display("FAIL sub_cout1: got %b expected 1", cout); end
    release_out;
    sub_i = 1'b0;
  endtask
`endif

  initial begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub_i = 1'b0;
`endif
    test_reset;
    test_add_basic;
    test_carry;
    test_reset_in_add;
    test_backpressure;
    test_operand_change;
    test_back_to_back;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    test_sub;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
